// File: rtl/morse_round_ctrl.sv
// Round sequencer for the two-player morse game: code entry, guesser load, miss counting, win score.
// Optional macro ROUND_TIMER_EN adds a guess-phase timeout of TIMEOUT_CYCLES cycles.
module morse_round_ctrl #(
    parameter int unsigned MAX_MISSES     = 3,
    parameter int unsigned SCORE_W        = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    input  logic               p1_done,
    input  logic [9:0]         p1_value,
    input  logic [1:0]         p2_result,
    input  logic               p2_complete,
    output logic               p1_en,
    output logic               p2_en,
    output logic               guess_load_n,
    output logic [9:0]         code_q,
    output logic               code_err,
    output logic [2:0]         attempts_left,
    output logic               round_done,
    output logic               win,
    output logic               lose,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_P1_ENTRY = 3'd1,
        S_ARM      = 3'd2,
        S_P2_GUESS = 3'd3,
        S_WIN      = 3'd4,
        S_LOSE     = 3'd5
    } state_t;

    // Strobe semantics: p1_done, start, abort and p2_complete are level qualifiers
    // sampled on every rising clock edge in the states that honour them; there is
    // no back-pressure. guess_load_n is low for exactly the single ARM cycle.

    state_t               state_q;
    state_t               state_d;
    logic [9:0]           code_d;
    logic [2:0]           attempts_d;
    logic [SCORE_W-1:0]   score_d;
    logic                 code_err_d;
    logic                 timeout;

`ifdef ROUND_TIMER_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] timer_q;

    // Loaded during ARM so it holds TIMEOUT_CYCLES-1 on the first guess cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            timer_q <= '0;
        end else if (state_q == S_ARM) begin
            timer_q <= TW'(TIMEOUT_CYCLES - 1);
        end else if (state_q == S_P2_GUESS && timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
        end
    end

    assign timeout = (state_q == S_P2_GUESS) && (timer_q == '0);
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            code_q        <= '0;
            attempts_left <= '0;
            score         <= '0;
            code_err      <= 1'b0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            attempts_left <= attempts_d;
            score         <= score_d;
            code_err      <= code_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        attempts_d = attempts_left;
        score_d    = score;
        code_err_d = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            code_d  = '0;
        end else begin
            case (state_q)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (start) begin
                        state_d    = S_P1_ENTRY;
                        attempts_d = 3'(MAX_MISSES);
                        code_d     = '0;
                    end
                end
                S_P1_ENTRY: begin
                    if (p1_done) begin
                        // An all-zero code cannot be guessed, so it is refused.
                        if (p1_value != '0) begin
                            code_d  = p1_value;
                            state_d = S_ARM;
                        end else begin
                            code_err_d = 1'b1;
                        end
                    end
                end
                S_ARM: begin
                    state_d = S_P2_GUESS;
                end
                S_P2_GUESS: begin
                    if (p2_complete) begin
                        state_d = S_WIN;
                        if (score != '1) begin
                            score_d = score + 1'b1;
                        end
                    end else if (p2_result == 2'b10) begin
                        if (attempts_left > 3'd1) begin
                            attempts_d = attempts_left - 3'd1;
                        end else begin
                            attempts_d = '0;
                            state_d    = S_LOSE;
                        end
                    end else if (timeout) begin
                        state_d = S_LOSE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign state        = state_q;
    assign p1_en        = (state_q == S_P1_ENTRY);
    assign p2_en        = (state_q == S_P2_GUESS);
    assign guess_load_n = (state_q != S_ARM);
    assign win          = (state_q == S_WIN);
    assign lose         = (state_q == S_LOSE);
    assign round_done   = (state_q == S_WIN) || (state_q == S_LOSE);

endmodule

// File: tb/tb_morse_round_ctrl.sv
// Scoreboard bench for morse_round_ctrl: a behavioural round model predicts every cycle's outputs.
module tb_morse_round_ctrl;

    localparam int MAXM = 3;
    localparam int SW   = 3;
    localparam int TO   = 8;
    localparam int EW   = 23 + SW;
`ifdef ROUND_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          p1_done = 1'b0;
    logic [9:0]    p1_value = '0;
    logic [1:0]    p2_result = '0;
    logic          p2_complete = 1'b0;
    logic          p1_en;
    logic          p2_en;
    logic          guess_load_n;
    logic [9:0]    code_q;
    logic          code_err;
    logic [2:0]    attempts_left;
    logic          round_done;
    logic          win;
    logic          lose;
    logic [SW-1:0] score;
    logic [2:0]    state;

    morse_round_ctrl #(
        .MAX_MISSES(MAXM),
        .SCORE_W(SW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .start(start),
        .abort(abort),
        .p1_done(p1_done),
        .p1_value(p1_value),
        .p2_result(p2_result),
        .p2_complete(p2_complete),
        .p1_en(p1_en),
        .p2_en(p2_en),
        .guess_load_n(guess_load_n),
        .code_q(code_q),
        .code_err(code_err),
        .attempts_left(attempts_left),
        .round_done(round_done),
        .win(win),
        .lose(lose),
        .score(score),
        .state(state)
    );

    // Clock / reset
    always #5 clock = ~clock;

    // Reference model: round phase numbered 0 idle, 1 entry, 2 arm, 3 guess, 4 won, 5 lost.
    int         m_phase;
    logic [9:0] m_code;
    int         m_att;
    int         m_score;
    bit         m_err;
    int         m_guess_cycles;

    logic [EW-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic model_reset();
        m_phase = 0; m_code = '0; m_att = 0; m_score = 0; m_err = 1'b0; m_guess_cycles = 0;
    endtask

    task automatic model_step(input logic st, input logic ab, input logic pd,
                              input logic [9:0] pv, input logic [1:0] pr, input logic pc);
        int waited;
        m_err = 1'b0;
        if (ab) begin
            m_phase = 0;
            m_code  = '0;
        end else if (m_phase == 0 || m_phase == 4 || m_phase == 5) begin
            if (st) begin
                m_phase = 1; m_att = MAXM; m_code = '0;
            end
        end else if (m_phase == 1) begin
            if (pd && pv != 10'd0) begin
                m_code = pv; m_phase = 2;
            end else if (pd) begin
                m_err = 1'b1;
            end
        end else if (m_phase == 2) begin
            m_phase = 3; m_guess_cycles = 0;
        end else if (m_phase == 3) begin
            waited = m_guess_cycles;
            m_guess_cycles++;
            if (pc) begin
                m_phase = 4;
                m_score = (m_score + 1 > (1 << SW) - 1) ? (1 << SW) - 1 : m_score + 1;
            end else if (pr == 2'b10) begin
                m_att = m_att - 1;
                if (m_att == 0) m_phase = 5;
            end else if (TIMER && waited == TO - 1) begin
                m_phase = 5;
            end
        end else begin
            m_phase = 0;
        end
    endtask

    function automatic logic [EW-1:0] model_vec();
        return {3'(m_phase), m_phase == 1, m_phase == 3, m_phase != 2, m_code, m_err,
                3'(m_att), (m_phase == 4 || m_phase == 5), m_phase == 4, m_phase == 5, SW'(m_score)};
    endfunction

    function automatic logic [EW-1:0] dut_vec();
        return {state, p1_en, p2_en, guess_load_n, code_q, code_err,
                attempts_left, round_done, win, lose, score};
    endfunction

    task automatic compare(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got state=%0d code=%h att=%0d score=%0d vec=%h, want state=%0d code=%h att=%0d score=%0d vec=%h",
                     name, $time, act[EW-1 -: 3], act[SW+17 -: 10], act[SW+6 -: 3], act[SW-1:0], act,
                     exp[EW-1 -: 3], exp[SW+17 -: 10], exp[SW+6 -: 3], exp[SW-1:0], exp);
        end
    endtask

    // Driver: inputs change on the falling edge, expectation for the next rising edge is queued.
    task automatic drive(input logic st, input logic ab, input logic pd,
                         input logic [9:0] pv, input logic [1:0] pr, input logic pc);
        @(negedge clock);
        start = st; abort = ab; p1_done = pd; p1_value = pv; p2_result = pr; p2_complete = pc;
        model_step(st, ab, pd, pv, pr, pc);
        exp_q.push_back(model_vec());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 10'd0, 2'b00, 1'b0);
    endtask

    // Monitor: one observation per rising edge, checked just after it.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() != 0) compare("cycle_outputs", dut_vec(), exp_q.pop_front());
    end

    initial begin
        model_reset();
        #3;
        compare("reset_values", dut_vec(), model_vec());
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;

        // Round 1: enter code, three misses to LOSE
        drive(1'b1, 1'b0, 1'b0, 10'd0, 2'b00, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 10'b0101110000, 2'b00, 1'b0);
        idle(2);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 10'd0, 2'b10, 1'b0);
        idle(1);

        // Round 2: correct symbols, then complete -> WIN, restart keeps score
        drive(1'b1, 1'b0, 1'b0, 10'd0, 2'b00, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 10'h170, 2'b00, 1'b0);
        idle(1);
        drive(1'b0, 1'b0, 1'b0, 10'd0, 2'b01, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 10'd0, 2'b01, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 10'd0, 2'b00, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 10'd0, 2'b00, 1'b0);

        // Zero code rejected, all-ones accepted; complete beats last miss; abort beats start
        drive(1'b0, 1'b0, 1'b1, 10'd0, 2'b00, 1'b0);
        idle(1);
        drive(1'b0, 1'b0, 1'b1, 10'h3FF, 2'b00, 1'b0);
        idle(1);
        drive(1'b0, 1'b0, 1'b0, 10'd0, 2'b10, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 10'd0, 2'b10, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 10'd0, 2'b10, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 10'd0, 2'b00, 1'b0);

        // Idle guessing (times out to LOSE when the timer is built in)
        drive(1'b1, 1'b0, 1'b0, 10'd0, 2'b00, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 10'h2A5, 2'b00, 1'b0);
        idle(TO + 4);

        // Asynchronous reset in the middle of a guess phase
        drive(1'b1, 1'b0, 1'b0, 10'd0, 2'b00, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 10'h011, 2'b00, 1'b0);
        idle(2);
        @(posedge clock);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        compare("async_reset", dut_vec(), model_vec());
        @(negedge clock);
        resetn = 1'b1;

        // Randomised rounds
        for (int i = 0; i < 3000; i++) begin
            logic [9:0] pv;
            pv = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom);
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 2) == 0,
                  pv, 2'($urandom), $urandom_range(0, 7) == 0);
        end
        idle(2);

        repeat (4) @(posedge clock);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
